accelerator_fnn_controller_sequencer: RTL and testbench

- Sequences the feed-forward controller layer of the NTM accelerator: H[l] = B[l] + sum_x W[l][x]*X[x], for l in 0..SIZE_L-1 and x in 0..SIZE_X-1.
- Uses a single multiply-accumulate datapath. The input vector is buffered once; bias and weight streams are then consumed row by row, and one H element is emitted per row.
- Sits between the NTM top-level control (START/READY) and the weight/bias/input memories or streams.

---
 rtl/accelerator_fnn_controller_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_accelerator_fnn_controller_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_fnn_controller_sequencer.sv
// Feed-forward layer sequencer: buffers X once, then per row takes one bias and SIZE_X weights into a single MAC and emits one saturated H.
// START to DONE is SIZE_X + SIZE_L*(SIZE_X+2) + 1 cycles unstalled; any stall on an ENABLE or on H_OUT_READY freezes state and counters.
module accelerator_fnn_controller_sequencer #(
    parameter int DATA_SIZE    = 64,
    parameter int FRAC_SIZE    = 32,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_X        = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    DONE,
    output logic                    ERROR,
    input  logic [CONTROL_SIZE-1:0] SIZE_X_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_L_IN,
    input  logic                    X_IN_ENABLE,
    output logic                    X_IN_READY,
    input  logic [DATA_SIZE-1:0]    X_IN,
    input  logic                    B_IN_ENABLE,
    output logic                    B_IN_READY,
    input  logic [DATA_SIZE-1:0]    B_IN,
    input  logic                    W_IN_ENABLE,
    output logic                    W_IN_READY,
    input  logic [DATA_SIZE-1:0]    W_IN,
    output logic                    H_OUT_ENABLE,
    input  logic                    H_OUT_READY,
    output logic [DATA_SIZE-1:0]    H_OUT,
    output logic [CONTROL_SIZE-1:0] H_OUT_L,
    output logic                    H_OUT_OVERFLOW
);

    localparam int XI_W  = (MAX_X > 1) ? $clog2(MAX_X) : 1;
    localparam int ACC_W = 2*DATA_SIZE + $clog2(MAX_X) + 1;
    localparam int PAD_B = ACC_W - DATA_SIZE - FRAC_SIZE;
    localparam int PAD_P = ACC_W - 2*DATA_SIZE;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_X = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_MAC    = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;

    logic [2:0]                r_state;
    logic [CONTROL_SIZE-1:0]   r_size_x;
    logic [CONTROL_SIZE-1:0]   r_size_l;
    logic [XI_W-1:0]           r_i;
    logic [CONTROL_SIZE-1:0]   r_l;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_SIZE-1:0]      r_h;
    logic                      r_ovf;
    logic                      r_done;
    logic                      r_error;
    logic [DATA_SIZE-1:0]      r_xbuf [MAX_X];

    logic                        w_illegal;
    logic                        w_last_i;
    logic                        w_last_l;
    logic signed [2*DATA_SIZE-1:0] w_w_ext;
    logic signed [2*DATA_SIZE-1:0] w_x_ext;
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]     w_bias_ext;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic signed [ACC_W-1:0]     w_shift;
    logic [ACC_W-DATA_SIZE:0]    w_hi;
    logic                        w_ovf;
    logic [DATA_SIZE-1:0]        w_sat;
    logic [DATA_SIZE-1:0]        w_h;

    assign w_illegal = (SIZE_X_IN == '0) || (SIZE_L_IN == '0) ||
                       (SIZE_X_IN > CONTROL_SIZE'(MAX_X));
    assign w_last_i  = (CONTROL_SIZE'(r_i) == (r_size_x - CONTROL_SIZE'(1)));
    assign w_last_l  = (r_l == (r_size_l - CONTROL_SIZE'(1)));

    // Bias is Q.FRAC; shifting it up aligns it with the Q.2*FRAC products.
    assign w_bias_ext = {{PAD_B{B_IN[DATA_SIZE-1]}}, B_IN, {FRAC_SIZE{1'b0}}};
    assign w_w_ext    = {{DATA_SIZE{W_IN[DATA_SIZE-1]}}, W_IN};
    assign w_x_ext    = {{DATA_SIZE{r_xbuf[r_i][DATA_SIZE-1]}}, r_xbuf[r_i]};
    assign w_prod     = w_w_ext * w_x_ext;
    assign w_acc_next = r_acc + {{PAD_P{w_prod[2*DATA_SIZE-1]}}, w_prod};

    // The result is formed from the final accumulate so H is ready on entry to EMIT.
    assign w_shift = w_acc_next >>> FRAC_SIZE;
    assign w_hi    = w_shift[ACC_W-1:DATA_SIZE-1];
    assign w_ovf   = ~((&w_hi) | (~|w_hi));
    assign w_sat   = w_shift[ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                      : {1'b0, {(DATA_SIZE-1){1'b1}}};
    assign w_h     = w_ovf ? w_sat : w_shift[DATA_SIZE-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_size_x <= '0;
            r_size_l <= '0;
            r_i      <= '0;
            r_l      <= '0;
            r_acc    <= '0;
            r_h      <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        if (w_illegal) begin
                            r_error <= 1'b1;
                        end else begin
                            r_size_x <= SIZE_X_IN;
                            r_size_l <= SIZE_L_IN;
                            r_i      <= '0;
                            r_l      <= '0;
                            r_acc    <= '0;
                            r_state  <= S_LOAD_X;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (X_IN_ENABLE) begin
                        if (w_last_i) begin
                            r_i     <= '0;
                            r_l     <= '0;
                            r_state <= S_LOAD_B;
                        end else begin
                            r_i <= r_i + XI_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (B_IN_ENABLE) begin
                        r_acc   <= w_bias_ext;
                        r_i     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (W_IN_ENABLE) begin
                        r_acc <= w_acc_next;
                        if (w_last_i) begin
                            r_i     <= '0;
                            r_h     <= w_h;
                            r_ovf   <= w_ovf;
                            r_state <= S_EMIT;
                        end else begin
                            r_i <= r_i + XI_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (H_OUT_READY) begin
                        if (w_last_l) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_l     <= r_l + CONTROL_SIZE'(1);
                            r_state <= S_LOAD_B;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if ((r_state == S_LOAD_X) && X_IN_ENABLE) begin
            r_xbuf[r_i] <= X_IN;
        end
    end

    assign READY          = (r_state == S_IDLE);
    assign X_IN_READY     = (r_state == S_LOAD_X);
    assign B_IN_READY     = (r_state == S_LOAD_B);
    assign W_IN_READY     = (r_state == S_MAC);
    assign H_OUT_ENABLE   = (r_state == S_EMIT);
    assign H_OUT          = r_h;
    assign H_OUT_L        = r_l;
    assign H_OUT_OVERFLOW = r_ovf;
    assign DONE           = r_done;
    assign ERROR          = r_error;

endmodule

// File: tb/tb_accelerator_fnn_controller_sequencer.sv
// Directed bench for the feed-forward sequencer: hand-computed Q32.32 vectors, stall patterns, saturation and illegal-size cases.
module tb_accelerator_fnn_controller_sequencer;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        READY;
    logic        DONE;
    logic        ERROR;
    logic [63:0] SIZE_X_IN;
    logic [63:0] SIZE_L_IN;
    logic        X_IN_ENABLE;
    logic        X_IN_READY;
    logic [63:0] X_IN;
    logic        B_IN_ENABLE;
    logic        B_IN_READY;
    logic [63:0] B_IN;
    logic        W_IN_ENABLE;
    logic        W_IN_READY;
    logic [63:0] W_IN;
    logic        H_OUT_ENABLE;
    logic        H_OUT_READY;
    logic [63:0] H_OUT;
    logic [63:0] H_OUT_L;
    logic        H_OUT_OVERFLOW;

    accelerator_fnn_controller_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .DONE(DONE), .ERROR(ERROR),
        .SIZE_X_IN(SIZE_X_IN), .SIZE_L_IN(SIZE_L_IN),
        .X_IN_ENABLE(X_IN_ENABLE), .X_IN_READY(X_IN_READY), .X_IN(X_IN),
        .B_IN_ENABLE(B_IN_ENABLE), .B_IN_READY(B_IN_READY), .B_IN(B_IN),
        .W_IN_ENABLE(W_IN_ENABLE), .W_IN_READY(W_IN_READY), .W_IN(W_IN),
        .H_OUT_ENABLE(H_OUT_ENABLE), .H_OUT_READY(H_OUT_READY), .H_OUT(H_OUT),
        .H_OUT_L(H_OUT_L), .H_OUT_OVERFLOW(H_OUT_OVERFLOW)
    );

    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] TWO  = 64'h0000_0002_0000_0000;
    localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MONE = 64'hFFFF_FFFF_0000_0000;

    int n_vec;
    int n_bad;

    logic [63:0] xv [16];
    logic [63:0] bv [4];
    logic [63:0] wv [64];
    logic [63:0] hexp [4];
    logic        oexp [4];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        START = 1'b0;
        X_IN_ENABLE = 1'b0; B_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0; H_OUT_READY = 1'b0;
        X_IN = '0; B_IN = '0; W_IN = '0;
    endtask

    // Drives one full operation from the xv/bv/wv tables and scores H against hexp/oexp.
    task automatic run_op(input string name, input int sx, input int sl, input bit stall,
                          input int exp_lat, input bit inject);
        int xi, bi, wi, hi, cyc, n_rdy;
        bit done_seen, err_seen, onehot_bad, have_prev, injected;
        logic [63:0] prev_h;
        xi = 0; bi = 0; wi = 0; hi = 0; cyc = 0;
        done_seen = 0; err_seen = 0; onehot_bad = 0; have_prev = 0; injected = 0;
        prev_h = '0;
        @(negedge CLK);
        START = 1'b1;
        SIZE_X_IN = 64'(sx);
        SIZE_L_IN = 64'(sl);
        while (cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            START = 1'b0;
            if (ERROR) err_seen = 1;
            if (DONE) begin
                done_seen = 1;
                break;
            end
            n_rdy = int'(X_IN_READY) + int'(B_IN_READY) + int'(W_IN_READY) + int'(H_OUT_ENABLE);
            if (n_rdy > 1) onehot_bad = 1;
            if (inject && W_IN_READY && !injected) begin
                START = 1'b1;
                SIZE_X_IN = '0;
                injected = 1;
            end
            X_IN_ENABLE = X_IN_READY && (!stall || $urandom_range(0, 2) != 0);
            X_IN = xv[xi % 16];
            if (X_IN_ENABLE) xi++;
            B_IN_ENABLE = B_IN_READY && (!stall || $urandom_range(0, 2) != 0);
            B_IN = bv[bi % 4];
            if (B_IN_ENABLE) bi++;
            W_IN_ENABLE = W_IN_READY && (!stall || $urandom_range(0, 2) != 0);
            W_IN = wv[wi % 64];
            if (W_IN_ENABLE) wi++;
            if (H_OUT_ENABLE) begin
                if (have_prev) chk({name, " h_stable"}, H_OUT, prev_h);
                H_OUT_READY = !stall || $urandom_range(0, 2) == 0;
                if (H_OUT_READY) begin
                    chk({name, " h"}, H_OUT, hexp[hi % 4]);
                    chk({name, " h_l"}, H_OUT_L, 64'(hi));
                    chk({name, " h_ovf"}, 64'(H_OUT_OVERFLOW), 64'(oexp[hi % 4]));
                    hi++;
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev_h = H_OUT;
                end
            end else begin
                H_OUT_READY = 1'b0;
            end
        end
        chk({name, " done"}, 64'(done_seen), 64'd1);
        chk({name, " h_count"}, 64'(hi), 64'(sl));
        chk({name, " onehot"}, 64'(onehot_bad), 64'd0);
        chk({name, " no_error"}, 64'(err_seen), 64'd0);
        chk({name, " ready_at_done"}, 64'(READY), 64'd1);
        if (!stall) chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
        idle_inputs();
    endtask

    task automatic try_bad(input string name, input logic [63:0] sx, input logic [63:0] sl);
        @(negedge CLK);
        START = 1'b1;
        SIZE_X_IN = sx;
        SIZE_L_IN = sl;
        @(negedge CLK);
        START = 1'b0;
        chk({name, " error"}, 64'(ERROR), 64'd1);
        chk({name, " ready"}, 64'(READY), 64'd1);
        chk({name, " streams"}, 64'({X_IN_READY, B_IN_READY, W_IN_READY, H_OUT_ENABLE}), 64'd0);
        @(negedge CLK);
        chk({name, " error_pulse"}, 64'(ERROR), 64'd0);
        chk({name, " stay_idle"}, 64'(READY), 64'd1);
    endtask

    task automatic load_2x2();
        xv[0] = ONE;  xv[1] = TWO;
        bv[0] = HALF; bv[1] = MONE;
        wv[0] = ONE;  wv[1] = '0; wv[2] = '0; wv[3] = ONE;
        hexp[0] = 64'h0000_0001_8000_0000; oexp[0] = 1'b0;
        hexp[1] = ONE;                     oexp[1] = 1'b0;
    endtask

    initial begin
        bit reached_mac;
        n_vec = 0;
        n_bad = 0;
        idle_inputs();
        SIZE_X_IN = '0;
        SIZE_L_IN = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst ready", 64'(READY), 64'd1);
        chk("rst flags", 64'({DONE, ERROR, H_OUT_OVERFLOW}), 64'd0);
        chk("rst streams", 64'({X_IN_READY, B_IN_READY, W_IN_READY, H_OUT_ENABLE}), 64'd0);
        chk("rst h_out", H_OUT, 64'd0);
        chk("rst h_l", H_OUT_L, 64'd0);
        RST = 1'b0;

        // 2x2 identity: H0 = 0.5 + 1.0 = 1.5, H1 = -1.0 + 2.0 = 1.0
        load_2x2();
        run_op("id2x2", 2, 2, 1'b0, 11, 1'b0);
        run_op("id2x2_bp", 2, 2, 1'b1, 0, 1'b0);
        run_op("id2x2_bp2", 2, 2, 1'b1, 0, 1'b0);

        // Mixed signs: 0.25 + 2*1.5 + 0.5*(-2) + (-4)*0.25 = 1.25
        xv[0] = 64'h0000_0001_8000_0000; xv[1] = 64'hFFFF_FFFE_0000_0000; xv[2] = 64'h0000_0000_4000_0000;
        bv[0] = 64'h0000_0000_4000_0000;
        wv[0] = TWO; wv[1] = HALF; wv[2] = 64'hFFFF_FFFC_0000_0000;
        hexp[0] = 64'h0000_0001_4000_0000; oexp[0] = 1'b0;
        run_op("mix3x1", 3, 1, 1'b0, 9, 1'b0);

        // Tiny products: -2^-64 floors to -2^-32, +2^-64 floors to 0
        xv[0] = 64'd1;
        bv[0] = '0; bv[1] = '0;
        wv[0] = 64'hFFFF_FFFF_FFFF_FFFF; wv[1] = 64'd1;
        hexp[0] = 64'hFFFF_FFFF_FFFF_FFFF; oexp[0] = 1'b0;
        hexp[1] = 64'd0;                   oexp[1] = 1'b0;
        run_op("floor1x2", 1, 2, 1'b0, 8, 1'b0);

        // 2^30 * 2^30 overflows Q32.32 in both directions
        xv[0] = 64'h4000_0000_0000_0000;
        bv[0] = '0;
        wv[0] = 64'h4000_0000_0000_0000;
        hexp[0] = 64'h7FFF_FFFF_FFFF_FFFF; oexp[0] = 1'b1;
        run_op("sat_pos", 1, 1, 1'b0, 5, 1'b0);
        wv[0] = 64'hC000_0000_0000_0000;
        hexp[0] = 64'h8000_0000_0000_0000; oexp[0] = 1'b1;
        run_op("sat_neg", 1, 1, 1'b0, 5, 1'b0);

        try_bad("bad_x0", 64'd0, 64'd1);
        try_bad("bad_x17", 64'd17, 64'd1);
        try_bad("bad_l0", 64'd2, 64'd0);

        // Full-depth X buffer, START (with an illegal size) injected during MAC must be ignored
        for (int k = 0; k < 16; k++) xv[k] = ONE;
        for (int k = 0; k < 48; k++) wv[k] = ONE;
        for (int k = 0; k < 3; k++) begin
            bv[k] = '0;
            hexp[k] = 64'h0000_0010_0000_0000;
            oexp[k] = 1'b0;
        end
        run_op("max16x3", 16, 3, 1'b0, 71, 1'b1);

        // Reset asserted while in MAC
        load_2x2();
        reached_mac = 0;
        @(negedge CLK);
        START = 1'b1;
        SIZE_X_IN = 64'd2;
        SIZE_L_IN = 64'd2;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (W_IN_READY) begin
                reached_mac = 1;
                break;
            end
            X_IN_ENABLE = X_IN_READY;
            X_IN = X_IN_READY ? (c == 0 ? ONE : TWO) : '0;
            B_IN_ENABLE = B_IN_READY;
            B_IN = HALF;
        end
        chk("rstmac reached", 64'(reached_mac), 64'd1);
        X_IN_ENABLE = 1'b0;
        B_IN_ENABLE = 1'b0;
        W_IN_ENABLE = 1'b1;
        W_IN = ONE;
        RST = 1'b1;
        @(negedge CLK);
        chk("rstmac ready", 64'(READY), 64'd1);
        chk("rstmac streams", 64'({X_IN_READY, B_IN_READY, W_IN_READY, H_OUT_ENABLE}), 64'd0);
        chk("rstmac done", 64'(DONE), 64'd0);
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        chk("rstmac no_done", 64'(DONE), 64'd0);
        chk("rstmac idle", 64'(READY), 64'd1);

        // A clean run after the abandoned one
        load_2x2();
        run_op("after_rst", 2, 2, 1'b0, 11, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
